order_fetch_responder: RTL and testbench

- Responder end of the instruction-fetch bus: receives the fetch stage's fetch address and returns the instruction word plus a completion flag.
- The fetch stage holds the address and stalls the pipeline while completion is low.
- Contains a direct-mapped, read-only instruction buffer. Hits complete in the same cycle; misses are refilled from a slower memory port using a req/ack handshake.
- Sits between the fetch stage and the instruction memory / bus arbiter.

---
 rtl/order_fetch_responder_pkg.sv | 20 ++
 rtl/order_buffer_ram.sv | 47 ++++
 rtl/order_fetch_responder.sv | 114 +++++++++++
 tb/tb_order_fetch_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/order_fetch_responder_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch responder.
package order_fetch_responder_pkg;

    // Opcode 31 in [31:27]; the core decodes it as an illegal instruction.
    localparam logic [31:0] FAULT_WORD_DEF  = 32'hF800_0000;
    localparam int unsigned OPC_MSB         = 31;
    localparam int unsigned OPC_LSB         = 27;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StErr
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr & ~WORD_ALIGN_MASK) == 32'h0;
    endfunction

endpackage

// File: rtl/order_buffer_ram.sv
// Direct-mapped line storage: async read, sync write, one-cycle clear of all valid bits.
module order_buffer_ram
    import order_fetch_responder_pkg::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 32 - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [TAG_W-1:0] wtag_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic             rvalid_o,
    output logic [TAG_W-1:0] rtag_o,
    output logic [31:0]      rdata_o
);

    localparam int unsigned Depth = 2 ** IDX_W;

    logic [Depth-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [Depth];
    logic [31:0]      data_q [Depth];

    // Clear wins over a same-cycle write so a flushed fill never becomes visible.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i && !clr_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/order_fetch_responder.sv
// Fetch-bus responder: same-cycle hits from a direct-mapped buffer, misses refilled via req/ack.
module order_fetch_responder
    import order_fetch_responder_pkg::*;
#(
    parameter int unsigned IDX_W      = 4,
    parameter logic [31:0] FAULT_WORD = FAULT_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] f_addr_i,
    output logic [31:0] f_data_o,
    output logic        f_cplt_o,
    input  logic        flush_i,
    output logic        m_req_o,
    output logic [31:0] m_addr_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_rdata_i,
    input  logic        m_err_i
);

    localparam int unsigned TagW = 32 - IDX_W - 2;

    fetch_state_e state_q, state_d;
    logic [31:0]  pend_addr_q, pend_addr_d;

    logic [IDX_W-1:0] f_idx;
    logic [TagW-1:0]  f_tag;
    logic             line_valid;
    logic [TagW-1:0]  line_tag;
    logic [31:0]      line_data;
    logic             aligned;
    logic             hit;
    logic             fault_pulse;
    logic             fill_we;

    assign f_idx   = f_addr_i[IDX_W+1:2];
    assign f_tag   = f_addr_i[31:IDX_W+2];
    assign aligned = is_word_aligned(f_addr_i);

    order_buffer_ram #(
        .IDX_W (IDX_W),
        .TAG_W (TagW)
    ) u_buffer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (flush_i),
        .we_i     (fill_we),
        .widx_i   (pend_addr_q[IDX_W+1:2]),
        .wtag_i   (pend_addr_q[31:IDX_W+2]),
        .wdata_i  (m_rdata_i),
        .ridx_i   (f_idx),
        .rvalid_o (line_valid),
        .rtag_o   (line_tag),
        .rdata_o  (line_data)
    );

    assign hit = line_valid && (line_tag == f_tag) && aligned && !flush_i;

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        fault_pulse = 1'b0;
        fill_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!aligned) begin
                    fault_pulse = 1'b1;
                end else if (!hit && !flush_i) begin
                    pend_addr_d = f_addr_i;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (m_ack_i) begin
                    fill_we = !m_err_i;
                    state_d = m_err_i ? StErr : StIdle;
                end
            end
            StErr: begin
                // Only the address that faulted may see the completion.
                fault_pulse = (f_addr_i == pend_addr_q) && !flush_i;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pend_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        f_cplt_o = 1'b0;
        f_data_o = 32'h0;
        if (!rst) begin
            f_cplt_o = hit || fault_pulse;
            if (hit) begin
                f_data_o = line_data;
            end else if (fault_pulse) begin
                f_data_o = FAULT_WORD;
            end
        end
    end

    assign m_req_o  = (state_q == StReq);
    assign m_addr_o = pend_addr_q & WORD_ALIGN_MASK;

endmodule

// File: tb/tb_order_fetch_responder.sv
// Directed plus randomized bench for order_fetch_responder against a line-map reference model.
module tb_order_fetch_responder;

    localparam logic [31:0] FaultWord = 32'hF800_0000;
    localparam int          MIdle = 0;
    localparam int          MReq  = 1;
    localparam int          MErr  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_addr;
    logic [31:0] f_data;
    logic        f_cplt;
    logic        flush;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        m_err;

    int checks = 0;
    int errors = 0;

    // Reference model: idx -> cached word address / data; absence means invalid.
    logic [31:0] line_addr [int];
    logic [31:0] line_data [int];
    int          ms   = MIdle;
    logic [31:0] pend = 32'h0;

    order_fetch_responder #(
        .IDX_W      (4),
        .FAULT_WORD (FaultWord)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .f_addr_i  (f_addr),
        .f_data_o  (f_data),
        .f_cplt_o  (f_cplt),
        .flush_i   (flush),
        .m_req_o   (m_req),
        .m_addr_o  (m_addr),
        .m_ack_i   (m_ack),
        .m_rdata_i (m_rdata),
        .m_err_i   (m_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, check mid-cycle against the model, then advance both.
    task automatic step(input logic [31:0] a, input logic fl, input logic ack,
                        input logic [31:0] rd, input logic er, input logic r);
        int          idx;
        logic        mhit;
        logic        mfault;
        logic        ecplt;
        logic [31:0] edata;
        f_addr  = a;
        flush   = fl;
        m_ack   = ack;
        m_rdata = rd;
        m_err   = er;
        rst     = r;
        #3;
        idx    = int'(a[5:2]);
        mhit   = line_addr.exists(idx) && (line_addr[idx] == a) && !fl;
        mfault = (ms == MIdle && a[1:0] != 2'b00) || (ms == MErr && a == pend && !fl);
        ecplt  = !r && (mhit || mfault);
        edata  = r ? 32'h0 : mhit ? line_data[idx] : mfault ? FaultWord : 32'h0;
        chk("f_cplt", {31'h0, f_cplt}, {31'h0, ecplt});
        chk("f_data", f_data, edata);
        chk("m_req", {31'h0, m_req}, {31'h0, ms == MReq});
        if (ms == MReq) chk("m_addr", m_addr, pend);
        if (r) begin
            line_addr.delete();
            line_data.delete();
            ms   = MIdle;
            pend = 32'h0;
        end else begin
            case (ms)
                MIdle: if (a[1:0] == 2'b00 && !mhit && !fl) begin
                    pend = a;
                    ms   = MReq;
                end
                MReq: if (ack) begin
                    if (!er) begin
                        line_addr[int'(pend[5:2])] = pend;
                        line_data[int'(pend[5:2])] = rd;
                    end
                    ms = er ? MErr : MIdle;
                end
                default: ms = MIdle;
            endcase
            if (fl) begin
                line_addr.delete();
                line_data.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic miss_fill(input logic [31:0] a, input int waits,
                             input logic [31:0] rd, input logic er);
        step(a, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int w = 0; w < waits; w++) step(a, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(a, 1'b0, 1'b1, rd, er, 1'b0);
    endtask

    initial begin
        f_addr  = 32'h100;
        flush   = 1'b0;
        m_ack   = 1'b0;
        m_rdata = 32'h0;
        m_err   = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        step(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("reset_m_addr", m_addr, 32'h0);

        // Zero-wait fill of 0x100, then hit.
        miss_fill(32'h100, 0, 32'h5800_0010, 1'b0);
        step(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("hit_data_const", f_data, 32'h5800_0010);

        // Same index, different tag replaces the line.
        miss_fill(32'h140, 1, 32'h1111_2222, 1'b0);
        step(32'h140, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        miss_fill(32'h100, 0, 32'h5800_0010, 1'b0);

        // Misaligned fetch faults in the same cycle.
        step(32'h102, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("misalign_const", f_data, 32'hF800_0000);

        // Errored refill, ERR cycle, then refetch misses again.
        miss_fill(32'h200, 3, 32'h0, 1'b1);
        step(32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        miss_fill(32'h200, 0, 32'h0000_0013, 1'b0);

        // Flush over a valid line, then flush coincident with ack.
        step(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(32'h100, 1'b1, 1'b1, 32'h7777_0000, 1'b0, 1'b0);
        step(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(32'h100, 1'b0, 1'b1, 32'h5800_0010, 1'b0, 1'b0);

        // Reset mid-refill, then a late ack is ignored.
        step(32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(32'h304, 1'b0, 1'b1, 32'hABCD_0000, 1'b0, 1'b0);
        step(32'h304, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

        // Address change during REQ: old fill completes, no false completion.
        step(32'h400, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(32'h408, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(32'h408, 1'b0, 1'b1, 32'h0400_0400, 1'b0, 1'b0);
        step(32'h408, 1'b0, 1'b1, 32'h0408_0408, 1'b0, 1'b0);
        step(32'h400, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Randomized traffic with aliasing addresses and a random memory.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic        fl;
            logic        ack;
            logic        er;
            logic        r;
            a   = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 11) == 0) a[1:0] = 2'($urandom_range(1, 3));
            fl  = ($urandom_range(0, 24) == 0);
            ack = (ms == MReq) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            er  = ($urandom_range(0, 5) == 0);
            r   = ($urandom_range(0, 99) == 0);
            step(a, fl, ack, $urandom, er, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
